// File: rtl/au_decode_pipe_if.sv
// Handshake bundle for au_decode_pipe: index stream in, decoded word stream out.
// Latency: none (wires only).
// Backpressure: carries in_ready/out_ready; the producer/consumer sides are set by the modports.
interface au_decode_pipe_if #(
  parameter int WIDTH = 3
);
  localparam int N = 1 << WIDTH;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     z;

  // Producer/consumer side (testbench or upstream/downstream glue).
  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, z
  );

  // Decoder side.
  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, z
  );
endinterface

// File: rtl/au_decode_pipe.sv
// Registered binary decoder (one-hot / thermometer / reverse thermometer) with a 2-entry skid buffer.
// Latency: 1 cycle from input accept to z/out_valid; full throughput when out_ready is held high.
// Backpressure: in_ready = ~skid_valid, purely registered, so out_ready has no combinational path to in_ready.
module au_decode_pipe #(
  parameter int WIDTH = 3,
  parameter int MODE  = 0
) (
  input  logic               clk,
  input  logic               rst,
  au_decode_pipe_if.slave    bus
);
  localparam int N = 1 << WIDTH;

  // Unsupported configurations stop elaboration instead of building a wrong decoder.
  if (WIDTH < 1 || MODE < 0 || MODE > 2) begin : g_bad_param
    $fatal(1, "au_decode_pipe: illegal parameters WIDTH=%0d MODE=%0d", WIDTH, MODE);
  end

  logic [N-1:0] or_q;   // output register, drives z
  logic         ov;     // output register holds a word
  logic [N-1:0] sk_q;   // skid register, catches one word while the consumer stalls
  logic         sv;     // skid register holds a word
  logic [N-1:0] dec;
  logic         in_fire;
  logic         out_fire;

  assign bus.in_ready  = ~sv;
  assign bus.out_valid = ov;
  assign bus.z         = or_q;

  assign in_fire  = bus.in_valid & ~sv;
  assign out_fire = ov & bus.out_ready;

  // Decode the incoming index according to MODE (unsigned compare per bit position).
  always_comb begin
    dec = '0;
    for (int i = 0; i < N; i++) begin
      case (MODE)
        0:       dec[i] = (i == int'(bus.a));
        1:       dec[i] = (i <= int'(bus.a));
        default: dec[i] = (i >= int'(bus.a));
      endcase
    end
  end

  // Skid-buffer update: drain skid first, otherwise load output or skid, otherwise retire output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_q <= '0;
      ov   <= 1'b0;
      sk_q <= '0;
      sv   <= 1'b0;
    end else begin
      if (sv && out_fire) begin
        // in_ready was low this cycle, so no new word competes with the skid drain.
        or_q <= sk_q;
        sv   <= 1'b0;
      end else if (in_fire && (!ov || out_fire)) begin
        or_q <= dec;
        ov   <= 1'b1;
      end else if (in_fire) begin
        // Output is occupied and stalled: park the new word.
        sk_q <= dec;
        sv   <= 1'b1;
      end else if (out_fire) begin
        // z keeps its last value; only the valid drops.
        ov   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_au_decode_pipe.sv
// Bench for au_decode_pipe: directed WIDTH=3 cases on all three modes plus randomized
// valid/ready traffic on every WIDTH=1..5 / MODE=0..2 combination against a queue model.
`timescale 1ns/1ps
module tb_au_decode_pipe;
  logic clk;
  int   vec_cnt;
  int   err_cnt;
  int   rand_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports mismatches.
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode from the mode definitions, using plain arithmetic.
  function automatic logic [63:0] dec_ref(input int w, input int m, input int a);
    logic [63:0] all_ones;
    all_ones = (64'd1 << (1 << w)) - 64'd1;
    case (m)
      0:       return 64'd1 << a;
      1:       return (64'd2 << a) - 64'd1;
      default: return all_ones & ~((64'd1 << a) - 64'd1);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed instances: WIDTH=3, one per MODE, common stimulus ----------------
  logic       d_rst;
  logic       d_vld;
  logic [2:0] d_a;
  logic       d_ordy;

  au_decode_pipe_if #(.WIDTH(3)) bus0 ();
  au_decode_pipe_if #(.WIDTH(3)) bus1 ();
  au_decode_pipe_if #(.WIDTH(3)) bus2 ();

  assign bus0.in_valid = d_vld;  assign bus0.a = d_a;  assign bus0.out_ready = d_ordy;
  assign bus1.in_valid = d_vld;  assign bus1.a = d_a;  assign bus1.out_ready = d_ordy;
  assign bus2.in_valid = d_vld;  assign bus2.a = d_a;  assign bus2.out_ready = d_ordy;

  au_decode_pipe #(.WIDTH(3), .MODE(0)) u_dut0 (.clk(clk), .rst(d_rst), .bus(bus0));
  au_decode_pipe #(.WIDTH(3), .MODE(1)) u_dut1 (.clk(clk), .rst(d_rst), .bus(bus1));
  au_decode_pipe #(.WIDTH(3), .MODE(2)) u_dut2 (.clk(clk), .rst(d_rst), .bus(bus2));

  // ---------------- randomized instances: every WIDTH/MODE combination ----------------
  for (genvar gw = 1; gw <= 5; gw++) begin : g_w
    for (genvar gm = 0; gm < 3; gm++) begin : g_m
      localparam int N = 1 << gw;
      logic rst_g;
      au_decode_pipe_if #(.WIDTH(gw)) bus ();
      au_decode_pipe #(.WIDTH(gw), .MODE(gm)) u_dut (.clk(clk), .rst(rst_g), .bus(bus));

      initial begin : p_rand
        logic [63:0] q[$];
        int          a_drv;
        int          rdy_pct;
        int          vld_pct;
        logic        fire_in;
        logic        fire_out;
        string       pfx;
        pfx = $sformatf("w%0d_m%0d", gw, gm);
        rst_g = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_g = 1'b0;
        for (int c = 0; c < 1500; c++) begin
          // Three traffic phases: free-flowing, heavy stall, mixed.
          rdy_pct = (c < 500) ? 90 : (c < 1000) ? 25 : 60;
          vld_pct = (c < 500) ? 80 : (c < 1000) ? 90 : 50;
          a_drv = $urandom_range(0, N - 1);
          bus.in_valid  = ($urandom_range(0, 99) < vld_pct);
          bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
          bus.a = bus.in_valid ? a_drv[gw-1:0] : 'x;
          @(posedge clk);
          fire_out = (q.size() > 0) && bus.out_ready;
          fire_in  = bus.in_valid && (q.size() < 2);
          if (fire_out) void'(q.pop_front());
          if (fire_in)  q.push_back(dec_ref(gw, gm, a_drv));
          #1;
          check_val({pfx, "_vld"}, 64'(bus.out_valid), 64'(q.size() > 0));
          check_val({pfx, "_rdy"}, 64'(bus.in_ready), 64'(q.size() < 2));
          if (q.size() > 0) check_val({pfx, "_z"}, 64'(bus.z), q[0]);
          // Occasional asynchronous reset in the middle of traffic.
          if ($urandom_range(0, 299) == 0) begin
            rst_g = 1'b1;
            bus.in_valid = 1'b0;
            #1;
            check_val({pfx, "_rst_vld"}, 64'(bus.out_valid), 64'd0);
            check_val({pfx, "_rst_rdy"}, 64'(bus.in_ready), 64'd1);
            check_val({pfx, "_rst_z"}, 64'(bus.z), 64'd0);
            q.delete();
            @(posedge clk);
            #1 rst_g = 1'b0;
          end
        end
        bus.in_valid = 1'b0;
        rand_done++;
      end
    end
  end

  // ---------------- directed sequence and summary ----------------
  initial begin : p_main
    logic [7:0] m1_tab [8];
    logic [7:0] m2_tab [8];
    int guard;
    m1_tab = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    m2_tab = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    vec_cnt = 0;
    err_cnt = 0;
    rand_done = 0;
    d_rst = 1'b1;
    d_vld = 1'b0;
    d_a = '0;
    d_ordy = 1'b0;
    step();
    step();
    check_val("rst_vld", 64'(bus0.out_valid), 64'd0);
    check_val("rst_z", 64'(bus0.z), 64'd0);
    check_val("rst_rdy", 64'(bus0.in_ready), 64'd1);
    d_rst = 1'b0;

    // MODE0 streaming, one word per cycle.
    d_ordy = 1'b1;
    d_vld = 1'b1;
    d_a = 3'd5; step();
    check_val("s5_z", 64'(bus0.z), 64'h20);
    check_val("s5_vld", 64'(bus0.out_valid), 64'd1);
    d_a = 3'd0; step();
    check_val("s0_z", 64'(bus0.z), 64'h01);
    check_val("s0_rdy", 64'(bus0.in_ready), 64'd1);
    d_a = 3'd7; step();
    check_val("s7_z", 64'(bus0.z), 64'h80);
    d_vld = 1'b0; step();
    check_val("drain_vld", 64'(bus0.out_valid), 64'd0);
    check_val("drain_zhold", 64'(bus0.z), 64'h80);

    // Sweep all indices, all three modes at once.
    for (int a = 0; a < 8; a++) begin
      d_vld = 1'b1;
      d_a = a[2:0];
      step();
      check_val($sformatf("sw_m0_a%0d", a), 64'(bus0.z), 64'd1 << a);
      check_val($sformatf("sw_m1_a%0d", a), 64'(bus1.z), 64'(m1_tab[a]));
      check_val($sformatf("sw_m2_a%0d", a), 64'(bus2.z), 64'(m2_tab[a]));
    end
    d_vld = 1'b0; step();

    // Backpressure: two accepts while stalled, then release.
    d_ordy = 1'b0;
    d_vld = 1'b1;
    d_a = 3'd1; step();
    check_val("bp1_z", 64'(bus0.z), 64'h02);
    check_val("bp1_rdy", 64'(bus0.in_ready), 64'd1);
    d_a = 3'd2; step();
    check_val("bp2_z", 64'(bus0.z), 64'h02);
    check_val("bp2_rdy", 64'(bus0.in_ready), 64'd0);
    d_vld = 1'b0; step();
    check_val("bp_hold_z", 64'(bus0.z), 64'h02);
    check_val("bp_hold_vld", 64'(bus0.out_valid), 64'd1);
    d_ordy = 1'b1; step();
    check_val("bp_rel_z", 64'(bus0.z), 64'h04);
    check_val("bp_rel_vld", 64'(bus0.out_valid), 64'd1);
    check_val("bp_rel_rdy", 64'(bus0.in_ready), 64'd1);
    step();
    check_val("bp_empty_vld", 64'(bus0.out_valid), 64'd0);

    // Simultaneous in/out fire with only the output register full.
    d_ordy = 1'b0;
    d_vld = 1'b1;
    d_a = 3'd4; step();
    check_val("sim_load_z", 64'(bus0.z), 64'h10);
    d_ordy = 1'b1;
    d_a = 3'd6; step();
    check_val("sim_z", 64'(bus0.z), 64'h40);
    check_val("sim_vld", 64'(bus0.out_valid), 64'd1);
    check_val("sim_rdy", 64'(bus0.in_ready), 64'd1);
    d_vld = 1'b0; step();
    check_val("sim_done_vld", 64'(bus0.out_valid), 64'd0);

    // Reset with both registers full, taking effect without a clock edge.
    d_ordy = 1'b0;
    d_vld = 1'b1;
    d_a = 3'd1; step();
    d_a = 3'd2; step();
    check_val("mid_full_rdy", 64'(bus0.in_ready), 64'd0);
    #2;
    d_rst = 1'b1;
    d_vld = 1'b0;
    #1;
    check_val("mid_rst_vld", 64'(bus0.out_valid), 64'd0);
    check_val("mid_rst_z", 64'(bus0.z), 64'h00);
    check_val("mid_rst_rdy", 64'(bus0.in_ready), 64'd1);
    step();
    d_rst = 1'b0;
    d_ordy = 1'b1;
    step();
    check_val("post_rst_idle", 64'(bus0.out_valid), 64'd0);
    d_vld = 1'b1;
    d_a = 3'd3; step();
    check_val("post_rst_z", 64'(bus0.z), 64'h08);
    check_val("post_rst_vld", 64'(bus0.out_valid), 64'd1);
    d_vld = 1'b0; step();

    // Wait (bounded) for all randomized instances to finish.
    guard = 0;
    while (rand_done < 15 && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    check_val("rand_finished", 64'(rand_done), 64'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
